// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Circular byte queue between instruction fetch and the decoder. Fetch
//   pushes one byte per cycle. The decoder sees a PEEK-byte window that
//   starts at the head, so the opcode and its operands arrive together.
//   The decoder retires 1..PEEK bytes per cycle. A taken branch flushes the
//   whole queue.
//
// Ports
//   queue_clk        clock, rising edge
//   queue_reset      asynchronous active-high reset
//   queue_flush      synchronous flush; wins over push and pull
//   queue_in/push    fetched byte and its write strobe
//   queue_ready      space available (count < DEPTH)
//   queue_out        head window, byte i at [i*DATA_W +: DATA_W], byte 0 = head
//   queue_valid      thermometer valid per window byte (count > i)
//   queue_pull/len   retire queue_pull_len bytes (1..PEEK)
//   queue_pull_err   one-cycle pulse after a rejected pull
//   queue_count      occupancy 0..DEPTH
//   queue_empty/full occupancy flags
module inst_prefetch_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,   // power of two, >= PEEK, >= 2
    parameter int PEEK   = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int LEN_W  = $clog2(PEEK + 1)
) (
    input  logic                   queue_clk,
    input  logic                   queue_reset,
    input  logic                   queue_flush,
    input  logic [DATA_W-1:0]      queue_in,
    input  logic                   queue_push,
    output logic                   queue_ready,
    output logic [PEEK*DATA_W-1:0] queue_out,
    output logic [PEEK-1:0]        queue_valid,
    input  logic                   queue_pull,
    input  logic [LEN_W-1:0]       queue_pull_len,
    output logic                   queue_pull_err,
    output logic [CNT_W-1:0]       queue_count,
    output logic                   queue_empty,
    output logic                   queue_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              pull_err;

    logic              push_ok, pull_ok, pull_bad;
    logic [CNT_W-1:0]  pull_amt;

    // Push/pull decisions use only the registered count: a pull in the same
    // cycle never makes room for that cycle's push.
    assign push_ok  = queue_push & (count < CNT_W'(DEPTH)) & ~queue_flush;
    assign pull_bad = (queue_pull_len > LEN_W'(PEEK)) |
                      (CNT_W'(queue_pull_len) > count);
    assign pull_ok  = queue_pull & (queue_pull_len != '0) & ~pull_bad & ~queue_flush;
    assign pull_amt = pull_ok ? CNT_W'(queue_pull_len) : '0;

    // Storage is deliberately not reset; the valid mask hides stale entries.
    always_ff @(posedge queue_clk) begin
        if (push_ok)
            mem[tail] <= queue_in;
    end

    always_ff @(posedge queue_clk or posedge queue_reset) begin
        if (queue_reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pull_err <= 1'b0;
        end else if (queue_flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pull_err <= 1'b0;
        end else begin
            if (push_ok)
                tail <= tail + 1'b1;
            if (pull_ok)
                head <= head + PTR_W'(queue_pull_len);
            count    <= count + CNT_W'(push_ok) - pull_amt;
            // A zero-length pull counts as a no-op, not as an error.
            pull_err <= queue_pull & (queue_pull_len != '0) & pull_bad;
        end
    end

    // Head window: the pointer sum wraps modulo DEPTH on its own.
    for (genvar i = 0; i < PEEK; i++) begin : g_win
        logic [PTR_W-1:0] idx;
        assign idx            = head + PTR_W'(i);
        assign queue_valid[i] = count > CNT_W'(i);
        assign queue_out[i*DATA_W +: DATA_W] = queue_valid[i] ? mem[idx] : '0;
    end

    assign queue_count    = count;
    assign queue_empty    = (count == '0);
    assign queue_full     = (count == CNT_W'(DEPTH));
    assign queue_ready    = ~queue_full;
    assign queue_pull_err = pull_err;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed test of inst_prefetch_queue (DATA_W=8, DEPTH=16, PEEK=3).
// Inputs change 1 ns after each rising edge, and outputs are checked at that
// same point. As a result, every check sees the state left by the edge just taken.
module tb_inst_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  din;
    logic        push;
    logic        ready;
    logic [23:0] dout;
    logic [2:0]  valid;
    logic        pull;
    logic [1:0]  plen;
    logic        perr;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int n_assert = 0;
    int n_fail   = 0;

    inst_prefetch_queue dut (
        .queue_clk      (clk),
        .queue_reset    (rst),
        .queue_flush    (flush),
        .queue_in       (din),
        .queue_push     (push),
        .queue_ready    (ready),
        .queue_out      (dout),
        .queue_valid    (valid),
        .queue_pull     (pull),
        .queue_pull_len (plen),
        .queue_pull_err (perr),
        .queue_count    (count),
        .queue_empty    (empty),
        .queue_full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pull = 1'b0; plen = 2'd0; flush = 1'b0; din = 8'h00;
    endtask

    task automatic do_push(input logic [7:0] b);
        push = 1'b1; din = b; tick(); idle();
    endtask

    task automatic do_pull(input logic [1:0] n);
        pull = 1'b1; plen = n; tick(); idle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1; #1;
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_empty", 32'(empty), 32'd1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        // Reset state.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_err",   32'(perr),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_out",   32'(dout),  32'd0);
        tick(); tick();
        rst = 1'b0;

        // Two pushes show up in the window.
        do_push(8'hA9);
        chk("p1_count", 32'(count), 32'd1);
        chk("p1_valid", 32'(valid), 32'b001);
        do_push(8'h05);
        chk("p2_count", 32'(count), 32'd2);
        chk("p2_valid", 32'(valid), 32'b011);
        chk("p2_out",   32'(dout),  32'h0005A9);

        // Fill to 16 entries, then push once more while full.
        pulse_reset();
        for (int i = 0; i < 16; i++) do_push(8'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_ready", 32'(ready), 32'd0);
        chk("fill_count", 32'(count), 32'd16);
        do_push(8'hFF);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_out",   32'(dout),  32'h020100);
        chk("drop_err",   32'(perr),  32'd0);

        // Drain 12, refill 12 so the tail wraps, then read across the end of the array.
        for (int i = 0; i < 4; i++) do_pull(2'd3);
        chk("drain_count", 32'(count), 32'd4);
        chk("drain_out",   32'(dout),  32'h0E0D0C);
        for (int i = 0; i < 12; i++) do_push(8'(8'h10 + i));
        chk("refill_count", 32'(count), 32'd16);
        do_pull(2'd3);
        chk("wrap_count", 32'(count), 32'd13);
        chk("wrap_out",   32'(dout),  32'h11100F);

        // Reach count=2 (head 10), then an over-length pull is rejected.
        for (int i = 0; i < 3; i++) do_pull(2'd3);
        do_pull(2'd2);
        chk("c2_count", 32'(count), 32'd2);
        chk("c2_valid", 32'(valid), 32'b011);
        chk("c2_out",   32'(dout),  32'h001B1A);
        do_pull(2'd3);
        chk("rej_err",   32'(perr),  32'd1);
        chk("rej_count", 32'(count), 32'd2);
        chk("rej_out",   32'(dout),  32'h001B1A);
        tick();
        chk("rej_err_clr", 32'(perr),  32'd0);
        chk("rej_count2",  32'(count), 32'd2);
        do_pull(2'd0);
        chk("len0_count", 32'(count), 32'd2);
        chk("len0_err",   32'(perr),  32'd0);

        // Full queue: push and pull in the same cycle. The push is dropped and the pull applies.
        pulse_reset();
        for (int i = 0; i < 16; i++) do_push(8'(8'h40 + i));
        push = 1'b1; din = 8'h20; pull = 1'b1; plen = 2'd1; tick(); idle();
        chk("fp_count", 32'(count), 32'd15);
        chk("fp_out",   32'(dout),  32'h434241);
        chk("fp_ready", 32'(ready), 32'd1);
        // Not full: the push and the pull both apply.
        push = 1'b1; din = 8'h50; pull = 1'b1; plen = 2'd1; tick(); idle();
        chk("pp_count", 32'(count), 32'd15);
        chk("pp_out",   32'(dout),  32'h444342);
        chk("pp_full",  32'(full),  32'd0);

        // Flush wins over the push and the pull in the same cycle.
        pulse_reset();
        for (int i = 0; i < 7; i++) do_push(8'(8'h60 + i));
        chk("c7_count", 32'(count), 32'd7);
        chk("c7_out",   32'(dout),  32'h626160);
        flush = 1'b1; push = 1'b1; din = 8'h33; pull = 1'b1; plen = 2'd2; tick(); idle();
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_valid", 32'(valid), 32'd0);
        chk("fl_out",   32'(dout),  32'd0);
        chk("fl_err",   32'(perr),  32'd0);
        do_push(8'h77);
        chk("post_fl_out",   32'(dout),  32'h000077);
        chk("post_fl_count", 32'(count), 32'd1);

        // Reset in the middle of traffic clears the queue without waiting for a clock edge.
        do_push(8'h78);
        do_push(8'h79);
        chk("pre_rst_count", 32'(count), 32'd3);
        pulse_reset();
        chk("mid_rst_valid", 32'(valid), 32'd0);
        do_push(8'h5A);
        chk("post_rst_out", 32'(dout), 32'h00005A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Parametrised circular byte queue between instruction fetch and the prime decoder.
- Accepts one fetched byte per cycle and exposes a PEEK-byte window starting at the head, so the decoder sees opcode plus operands at once.
- Retires 1..PEEK bytes per cycle, matching the decoded instruction length.
- Flushes on a taken branch; adds occupancy reporting and error signalling.

Parameters:
DATA_W, 8, bits per queue entry
DEPTH, 16, number of entries; must be a power of two, at least PEEK
PEEK, 3, bytes exposed in the head window; equals the maximum instruction length
CNT_W, $clog2(DEPTH+1), width of the occupancy count
LEN_W, $clog2(PEEK+1), width of the pull length

Ports:
queue_clk  in  1  clock; all state updates on its rising edge
queue_reset  in  1  asynchronous, active-high reset
queue_flush  in  1  synchronous flush (branch taken or PC reload)
queue_in  in  DATA_W  fetched byte
queue_push  in  1  write queue_in this cycle
queue_ready  out  1  space available (count < DEPTH)
queue_out  out  PEEK*DATA_W  head window; byte i at bits [i*DATA_W +: DATA_W], byte 0 is the head
queue_valid  out  PEEK  per-byte valid; bit i = (count > i), thermometer coded
queue_pull  in  1  retire bytes this cycle
queue_pull_len  in  LEN_W  number of bytes to retire, 1..PEEK
queue_pull_err  out  1  one-cycle pulse when a pull is rejected
queue_count  out  CNT_W  current occupancy, 0..DEPTH
queue_empty  out  1  count == 0
queue_full  out  1  count == DEPTH

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Head pointer, tail pointer and count go to 0.
  - queue_empty=1, queue_full=0, queue_ready=1, queue_pull_err=0, queue_valid=0.
  - queue_out is all zeros.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents; the first push after deassertion lands in entry 0.
- Storage: DEPTH x DATA_W register array. Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. count is kept as a separate register.
- Push acceptance: push_ok = queue_push & (count < DEPTH) & ~queue_flush.
  - Uses the registered count. A pull in the same cycle does not free space for that cycle's push (no bypass).
  - A push while full is silently dropped, with no error.
- Pull acceptance: pull_ok = queue_pull & (queue_pull_len != 0) & (queue_pull_len <= PEEK) & (queue_pull_len <= count) & ~queue_flush.
  - On acceptance, the head advances by queue_pull_len, modulo DEPTH.
  - A pull with length 0 is a no-op with no error.
  - A pull with length > count or length > PEEK is rejected: no state change, and queue_pull_err=1 on the next cycle for exactly one cycle.
- Simultaneous push and pull: both apply. count_next = count + push_ok - (pull_ok ? queue_pull_len : 0).
  - Pushed data never forwards into the same cycle's window.
- Flush has priority over push and pull in the same cycle:
  - Next cycle: head = tail = 0, count = 0, queue_pull_err = 0.
  - The byte pushed in the flush cycle is discarded.
- Window outputs (combinational from registered state):
  - queue_out byte i = mem[(head + i) mod DEPTH] when count > i, otherwise zero.
  - Window reads wrap across the end of the array.
- Latency:
  - A pushed byte appears on queue_out and queue_valid one cycle after its push edge.
  - A pull takes effect on the window one cycle after its edge.
- Status flags queue_empty, queue_full and queue_ready are derived from the registered count; they are never glitch-driven by inputs.
- Invariants: 0 <= count <= DEPTH, and tail = (head + count) mod DEPTH at all times.

Test Plan:
- Reset, then push 0xA9, 0x05 on consecutive cycles -> one cycle after the second push: queue_count=2, queue_valid=3'b011, queue_out low bytes 0xA9, 0x05, byte 2 = 0x00.
- Push 0x00..0x0F (16 bytes), then push 0xFF -> queue_full=1, queue_ready=0, queue_count=16; 0xFF dropped, head byte still 0x00.
- From full, pull len 3 four times, then push 0x10..0x1B so the tail wraps; pull len 3 with head at index 15 -> window reads mem[15], mem[0], mem[1] = 0x0F, 0x10, 0x11.
- count=2, pull len 3 -> no change, queue_pull_err high for exactly one cycle, queue_count stays 2.
- count=16, push 0x20 with pull len 1 in the same cycle -> push dropped, count=15, head advances by one.
- count=7, queue_flush with push 0x33 and pull len 2 in the same cycle -> next cycle count=0, queue_empty=1, queue_valid=0; queue_reset pulsed mid-stream also gives count=0 immediately.
